// File: rtl/servant_sync2.sv
// rtl/servant_sync2.sv - two-flop synchronizer with parameterised reset level
module servant_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/servant_q_rx.sv
// rtl/servant_q_rx.sv - 8N1 serial receiver for the servant bit-banged q line
module servant_q_rx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned STOP_CHECK   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_q,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] L_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] L_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] L_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          w_q_s;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;

  servant_sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_q),
    .o_q   (w_q_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_q_s) begin
            r_cnt   <= L_HALF;
            r_state <= S_START;
          end
        end
        S_START: begin
          // Mid-start-bit recheck rejects short glitches on the line
          if (r_cnt == '0) begin
            if (w_q_s) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= L_FULL;
              r_idx   <= 3'd0;
              r_state <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {w_q_s, r_shift[7:1]};
            r_cnt   <= L_FULL;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        S_STOP: begin
          if (r_cnt == '0) begin
            if (w_q_s || (STOP_CHECK == 0)) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - L_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_busy      = (r_state != S_IDLE);

endmodule
